// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed uops by sqN, marks them executed on
// writeback, retires up to WIDTH_COM oldest executed uops per cycle, flushes on mispredict.
module reorder_buffer #(
    parameter int LENGTH     = 32,
    parameter int WIDTH_UOPS = 2,
    parameter int WIDTH_WR   = 3,
    parameter int WIDTH_COM  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH_UOPS-1:0]   IN_uopValid,
    input  logic [WIDTH_UOPS*6-1:0] IN_uopSqN,
    input  logic [WIDTH_UOPS*5-1:0] IN_uopNmDst,
    input  logic [WIDTH_UOPS*6-1:0] IN_uopTagDst,
    input  logic [WIDTH_WR-1:0]     IN_wbValid,
    input  logic [WIDTH_WR*6-1:0]   IN_wbSqN,
    input  logic                    IN_branchTaken,
    input  logic [5:0]              IN_branchSqN,
    output logic [WIDTH_COM-1:0]    OUT_comValid,
    output logic [WIDTH_COM*5-1:0]  OUT_comRegNm,
    output logic [WIDTH_COM*6-1:0]  OUT_comRegTag,
    output logic [WIDTH_COM*6-1:0]  OUT_comSqN,
    output logic [5:0]              OUT_curSqN,
    output logic [5:0]              OUT_maxSqN
);
    localparam int IDXW = $clog2(LENGTH);

    logic [LENGTH-1:0] r_valid;
    logic [LENGTH-1:0] r_exec;
    logic [4:0]        r_nm  [LENGTH];
    logic [5:0]        r_tag [LENGTH];
    logic [5:0]        r_sqn [LENGTH];
    logic [5:0]        r_baseSqN;

    logic [WIDTH_COM-1:0] w_comMask;
    logic [IDXW-1:0]      w_comIdx [WIDTH_COM];
    logic [5:0]           w_comCnt;
    logic                 w_chain;
    logic [5:0]           w_baseNext;
    logic [LENGTH-1:0]    w_flush;
    logic [IDXW-1:0]      w_insIdx [WIDTH_UOPS];
    logic [IDXW-1:0]      w_wbIdx  [WIDTH_WR];
    logic [WIDTH_WR-1:0]  w_wbHit;

    // True when a is strictly younger than b in the 6-bit wrapping sqN space.
    function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] d;
        d = a - b;
        return !d[5] && (d != 6'd0);
    endfunction

    // Commit decision uses only start-of-cycle state.
    always_comb begin
        w_comMask = '0;
        w_comCnt  = '0;
        w_chain   = 1'b1;
        for (int unsigned k = 0; k < WIDTH_COM; k++) begin
            w_comIdx[k]  = IDXW'(r_baseSqN + 6'(k));
            w_chain      = w_chain & r_valid[w_comIdx[k]] & r_exec[w_comIdx[k]];
            w_comMask[k] = w_chain;
            if (w_chain)
                w_comCnt = w_comCnt + 6'd1;
        end
        w_baseNext = r_baseSqN + w_comCnt;
    end

    always_comb begin
        w_flush = '0;
        for (int unsigned i = 0; i < LENGTH; i++)
            w_flush[i] = IN_branchTaken && r_valid[i] && younger(r_sqn[i], IN_branchSqN);
    end

    always_comb begin
        for (int unsigned s = 0; s < WIDTH_UOPS; s++)
            w_insIdx[s] = IN_uopSqN[s*6 +: IDXW];
        w_wbHit = '0;
        for (int unsigned p = 0; p < WIDTH_WR; p++) begin
            w_wbIdx[p] = IN_wbSqN[p*6 +: IDXW];
            w_wbHit[p] = IN_wbValid[p] && r_valid[w_wbIdx[p]] && !w_flush[w_wbIdx[p]]
                         && (r_sqn[w_wbIdx[p]] == IN_wbSqN[p*6 +: 6]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_exec        <= '0;
            r_baseSqN     <= '0;
            OUT_comValid  <= '0;
            OUT_comRegNm  <= '0;
            OUT_comRegTag <= '0;
            OUT_comSqN    <= '0;
            OUT_curSqN    <= '0;
            OUT_maxSqN    <= 6'(LENGTH - 1);
        end else begin
            for (int unsigned p = 0; p < WIDTH_WR; p++)
                if (w_wbHit[p])
                    r_exec[w_wbIdx[p]] <= 1'b1;

            for (int unsigned k = 0; k < WIDTH_COM; k++)
                if (w_comMask[k])
                    r_valid[w_comIdx[k]] <= 1'b0;

            for (int unsigned i = 0; i < LENGTH; i++)
                if (w_flush[i])
                    r_valid[i] <= 1'b0;

            // Inserts come last so a fresh entry always starts unexecuted.
            if (!IN_branchTaken) begin
                for (int unsigned s = 0; s < WIDTH_UOPS; s++) begin
                    if (IN_uopValid[s]) begin
                        r_valid[w_insIdx[s]] <= 1'b1;
                        r_exec[w_insIdx[s]]  <= 1'b0;
                        r_nm[w_insIdx[s]]    <= IN_uopNmDst[s*5 +: 5];
                        r_tag[w_insIdx[s]]   <= IN_uopTagDst[s*6 +: 6];
                        r_sqn[w_insIdx[s]]   <= IN_uopSqN[s*6 +: 6];
                    end
                end
            end

            r_baseSqN    <= w_baseNext;
            OUT_comValid <= w_comMask;
            for (int unsigned k = 0; k < WIDTH_COM; k++) begin
                if (w_comMask[k]) begin
                    OUT_comRegNm[k*5 +: 5]  <= r_nm[w_comIdx[k]];
                    OUT_comRegTag[k*6 +: 6] <= r_tag[w_comIdx[k]];
                    OUT_comSqN[k*6 +: 6]    <= r_sqn[w_comIdx[k]];
                end
            end
            OUT_curSqN <= w_baseNext;
            OUT_maxSqN <= w_baseNext + 6'(LENGTH - 1);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table plus hand sequences for
// wrap-around, full window and mid-operation reset.
module tb_reorder_buffer;
    localparam int LENGTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  IN_uopValid;
    logic [11:0] IN_uopSqN;
    logic [9:0]  IN_uopNmDst;
    logic [11:0] IN_uopTagDst;
    logic [2:0]  IN_wbValid;
    logic [17:0] IN_wbSqN;
    logic        IN_branchTaken;
    logic [5:0]  IN_branchSqN;
    logic [1:0]  OUT_comValid;
    logic [9:0]  OUT_comRegNm;
    logic [11:0] OUT_comRegTag;
    logic [11:0] OUT_comSqN;
    logic [5:0]  OUT_curSqN;
    logic [5:0]  OUT_maxSqN;

    reorder_buffer #(.LENGTH(LENGTH), .WIDTH_UOPS(2), .WIDTH_WR(3), .WIDTH_COM(2)) dut (
        .clk(clk), .rst(rst),
        .IN_uopValid(IN_uopValid), .IN_uopSqN(IN_uopSqN),
        .IN_uopNmDst(IN_uopNmDst), .IN_uopTagDst(IN_uopTagDst),
        .IN_wbValid(IN_wbValid), .IN_wbSqN(IN_wbSqN),
        .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN),
        .OUT_comValid(OUT_comValid), .OUT_comRegNm(OUT_comRegNm),
        .OUT_comRegTag(OUT_comRegTag), .OUT_comSqN(OUT_comSqN),
        .OUT_curSqN(OUT_curSqN), .OUT_maxSqN(OUT_maxSqN)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] uv;
        logic [5:0] us1, us0;
        logic [2:0] wv;
        logic [5:0] w2, w1, w0;
        logic       br;
        logic [5:0] bs;
        logic [1:0] cv;
        logic [5:0] cs1, cs0;
        logic       hold;
        logic [5:0] cur, mx;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [5:0] last_cur = 6'd0;

    // Stimulus rule: a uop with sqN s writes register s+3 (mod 32) into tag s+40 (mod 64).
    function automatic logic [4:0] nm_of(input logic [5:0] s);
        logic [5:0] t;
        t = s + 6'd3;
        return t[4:0];
    endfunction

    function automatic logic [5:0] tag_of(input logic [5:0] s);
        return s + 6'd40;
    endfunction

    task automatic add(input logic r, input logic [1:0] uv, input logic [5:0] us1, us0,
                       input logic [2:0] wv, input logic [5:0] w2, w1, w0,
                       input logic br, input logic [5:0] bs,
                       input logic [1:0] cv, input logic [5:0] cs1, cs0,
                       input logic hold, input logic [5:0] cur, mx);
        vec_t v;
        v = '{r, uv, us1, us0, wv, w2, w1, w0, br, bs, cv, cs1, cs0, hold, cur, mx};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] uv, input logic [5:0] us1, us0,
                         input logic [2:0] wv, input logic [5:0] w2, w1, w0,
                         input logic br, input logic [5:0] bs);
        logic [5:0] d;
        if (!r && !br) begin
            if (uv == 2'b11)
                assert (us1 != us0) else $error("illegal stimulus: duplicate sqN");
            d = us0 - last_cur;
            if (uv[0]) assert (d < 6'(LENGTH)) else $error("illegal stimulus: sqN outside window");
            d = us1 - last_cur;
            if (uv[1]) assert (d < 6'(LENGTH)) else $error("illegal stimulus: sqN outside window");
        end
        rst            = r;
        IN_uopValid    = uv;
        IN_uopSqN      = {us1, us0};
        IN_uopNmDst    = {nm_of(us1), nm_of(us0)};
        IN_uopTagDst   = {tag_of(us1), tag_of(us0)};
        IN_wbValid     = wv;
        IN_wbSqN       = {w2, w1, w0};
        IN_branchTaken = br;
        IN_branchSqN   = bs;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] cv, input logic [5:0] cs1, cs0,
                         input logic hold, input logic [5:0] cur, mx);
        logic       ok;
        logic [5:0] cs [2];
        cs[0] = cs0;
        cs[1] = cs1;
        ok = (OUT_comValid == cv) && (OUT_curSqN == cur) && (OUT_maxSqN == mx);
        for (int k = 0; k < 2; k++)
            if (cv[k] || hold)
                ok = ok && (OUT_comSqN[k*6 +: 6] == cs[k]) &&
                     (OUT_comRegNm[k*5 +: 5] == nm_of(cs[k])) &&
                     (OUT_comRegTag[k*6 +: 6] == tag_of(cs[k]));
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got comValid=%b comSqN=%0d/%0d regNm=%0d/%0d regTag=%0d/%0d cur=%0d max=%0d; want comValid=%b comSqN=%0d/%0d cur=%0d max=%0d",
                     name, OUT_comValid, OUT_comSqN[11:6], OUT_comSqN[5:0],
                     OUT_comRegNm[9:5], OUT_comRegNm[4:0], OUT_comRegTag[11:6], OUT_comRegTag[5:0],
                     OUT_curSqN, OUT_maxSqN, cv, cs1, cs0, cur, mx);
        end
        last_cur = cur;
    endtask

    initial begin
        // rst uv us1 us0 wv w2 w1 w0 br bs | cv cs1 cs0 hold cur max
        add(1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b011, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 2, 33);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 2, 33);
        // out-of-order writeback holds the head
        add(1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b01, 0, 2, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b011, 0, 2, 1, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 2, 33);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b01, 1, 2, 1, 3, 34);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3, 34);
        // branch flush at sqN 2; inserts of 6,7 in the branch cycle are dropped
        add(1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 3, 2, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 5, 4, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b11, 7, 6, 3'b000, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b111, 2, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 31);
        add(0, 2'b00, 0, 0, 3'b111, 5, 4, 3, 0, 0, 2'b11, 1, 0, 0, 2, 33);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b01, 1, 2, 1, 3, 34);
        add(0, 2'b11, 4, 3, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3, 34);
        add(0, 2'b01, 0, 5, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3, 34);
        add(0, 2'b00, 0, 0, 3'b111, 5, 4, 3, 0, 0, 2'b00, 0, 0, 0, 3, 34);
        add(0, 2'b00, 0, 0, 3'b011, 0, 7, 6, 0, 0, 2'b11, 4, 3, 0, 5, 36);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b01, 4, 5, 1, 6, 37);
        add(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4, 5, 1, 6, 37);

        drive(1'b1, 2'b00, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].uv, tbl[i].us1, tbl[i].us0, tbl[i].wv,
                  tbl[i].w2, tbl[i].w1, tbl[i].w0, tbl[i].br, tbl[i].bs);
            tick();
            check($sformatf("vec%0d", i), tbl[i].cv, tbl[i].cs1, tbl[i].cs0,
                  tbl[i].hold, tbl[i].cur, tbl[i].mx);
        end

        // Wrap-around: march baseSqN to 62 in pairs, then retire 62,63,0,1.
        drive(1'b1, 2'b00, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        check("wrap_rst", 2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 6'd31);
        for (int s = 0; s < 62; s += 2) begin
            drive(1'b0, 2'b11, 6'(s + 1), 6'(s), 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
            tick();
            check($sformatf("march_ins%0d", s), (s > 0) ? 2'b11 : 2'b00,
                  6'(s - 1), 6'(s - 2), 1'b0, 6'(s), 6'(s + 31));
            drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b011, 6'd0, 6'(s + 1), 6'(s), 1'b0, 6'd0);
            tick();
            check($sformatf("march_wb%0d", s), 2'b00, 6'd0, 6'd0, 1'b0, 6'(s), 6'(s + 31));
        end
        idle();
        tick();
        check("march_end", 2'b11, 6'd61, 6'd60, 1'b0, 6'd62, 6'd29);
        drive(1'b0, 2'b11, 6'd63, 6'd62, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        check("wrap_ins_a", 2'b00, 6'd0, 6'd0, 1'b0, 6'd62, 6'd29);
        drive(1'b0, 2'b11, 6'd1, 6'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        check("wrap_ins_b", 2'b00, 6'd0, 6'd0, 1'b0, 6'd62, 6'd29);
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b111, 6'd0, 6'd63, 6'd62, 1'b0, 6'd0);
        tick();
        check("wrap_wb_a", 2'b00, 6'd0, 6'd0, 1'b0, 6'd62, 6'd29);
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b001, 6'd0, 6'd0, 6'd1, 1'b0, 6'd0);
        tick();
        check("wrap_com_a", 2'b11, 6'd63, 6'd62, 1'b0, 6'd0, 6'd31);
        idle();
        tick();
        check("wrap_com_b", 2'b11, 6'd1, 6'd0, 1'b0, 6'd2, 6'd33);

        // Full window: allocate sqN 2..33 with no writeback.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 2'b11, 6'(2 * i + 3), 6'(2 * i + 2), 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
            tick();
            check($sformatf("fill%0d", i), 2'b00, 6'd0, 6'd0, 1'b0, 6'd2, 6'd33);
        end
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b001, 6'd0, 6'd0, 6'd2, 1'b0, 6'd0);
        tick();
        check("full_wb", 2'b00, 6'd0, 6'd0, 1'b0, 6'd2, 6'd33);
        idle();
        tick();
        check("full_com", 2'b01, 6'd1, 6'd2, 1'b1, 6'd3, 6'd34);

        // Reset with executed entries sitting at the head.
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b111, 6'd3, 6'd33, 6'd32, 1'b0, 6'd0);
        tick();
        check("pre_rst", 2'b00, 6'd0, 6'd0, 1'b0, 6'd3, 6'd34);
        drive(1'b1, 2'b00, 6'd0, 6'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        check("mid_rst", 2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 6'd31);
        idle();
        tick();
        check("post_rst_idle", 2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 6'd31);
        drive(1'b0, 2'b00, 6'd0, 6'd0, 3'b001, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        check("post_rst_wb", 2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 6'd31);
        idle();
        tick();
        check("post_rst_nocom", 2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 6'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer on the far side of the rename stage's commit interface.
- Records each renamed uop by sequence number (sqN) and marks it executed on writeback.
- Retires up to WIDTH_COM oldest executed uops per cycle, driving comValid/comRegNm/comRegTag/comSqN back into rename.
- Discards younger entries on a taken branch and publishes the sqN window limit the front end must respect.

Parameters:
- LENGTH, 32: number of entries; power of two, at most 32; entry index = sqN[log2(LENGTH)-1:0].
- WIDTH_UOPS, 2: renamed uops accepted per cycle.
- WIDTH_WR, 3: writeback ports.
- WIDTH_COM, 2: maximum commits per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- IN_uopValid  in  WIDTH_UOPS  per-slot renamed uop valid.
- IN_uopSqN  in  WIDTH_UOPS*6  sqN per slot.
- IN_uopNmDst  in  WIDTH_UOPS*5  architectural destination; 0 = none.
- IN_uopTagDst  in  WIDTH_UOPS*6  physical destination tag.
- IN_wbValid  in  WIDTH_WR  writeback valid.
- IN_wbSqN  in  WIDTH_WR*6  sqN of the completed uop.
- IN_branchTaken  in  1  mispredict; flush everything younger than IN_branchSqN.
- IN_branchSqN  in  6  sqN of the mispredicting uop.
- OUT_comValid  out  WIDTH_COM  commit valid per slot, in age order (slot 0 oldest).
- OUT_comRegNm  out  WIDTH_COM*5  committed architectural register.
- OUT_comRegTag  out  WIDTH_COM*6  committed physical tag.
- OUT_comSqN  out  WIDTH_COM*6  committed sqN.
- OUT_curSqN  out  6  sqN of the oldest uncommitted entry (baseSqN).
- OUT_maxSqN  out  6  baseSqN + LENGTH - 1 (mod 64); the front end must not allocate beyond it.

Behaviour:
- State:
  - Per entry: valid, executed, nmDst[5], tagDst[6], sqN[6].
  - Pointer baseSqN[6].
- Reset (synchronous, wins over all inputs):
  - All entries valid=0, executed=0.
  - baseSqN=0.
  - OUT_comValid=0; OUT_comRegNm/OUT_comRegTag/OUT_comSqN=0.
  - OUT_curSqN=0; OUT_maxSqN=LENGTH-1.
- Insert:
  - For each slot with IN_uopValid set, write entry[IN_uopSqN index] with valid=1, executed=0, and the slot's nmDst, tagDst and sqN.
  - Upstream guarantees no two slots carry the same sqN and every sqN lies in [baseSqN, OUT_maxSqN]; the bench asserts this.
- Writeback:
  - For each port with IN_wbValid set, if entry[index] is valid and entry.sqN == IN_wbSqN, set executed=1. Otherwise ignore (stale or flushed).
  - Ports with equal sqN are harmless.
- Commit (evaluated on state at the start of the cycle):
  - Slot k commits iff slots 0..k-1 commit and entry[baseSqN+k] is valid and executed.
  - Committed entries: valid cleared.
  - baseSqN += number committed, mod 64.
  - Outputs registered, so commit info appears the cycle after the decision. Latency from writeback to OUT_comValid is 2 cycles minimum.
  - nmDst=0 entries still commit (OUT_comValid=1, OUT_comRegNm=0); rename ignores them.
  - Non-committing slots: OUT_comValid=0; data fields hold their previous values.
- Branch flush (IN_branchTaken):
  - Every valid entry with $signed(entry.sqN - IN_branchSqN) > 0 (6-bit difference) has valid cleared.
  - Entries with difference <= 0 are untouched.
  - Commit proceeds the same cycle on pre-flush state. Only entries at or older than the branch can be at the head, so flushing never removes a committing entry.
  - IN_uopValid in a branch cycle is ignored (no insert).
  - Writebacks in a branch cycle are applied only to surviving entries.
- Same-cycle interactions:
  - A writeback to the head entry in cycle N allows commit in cycle N+1, not N.
  - An insert to an index committing in the same cycle is impossible by the window rule.
- Wrap-around:
  - sqN is 6-bit and wraps mod 64; index wraps mod LENGTH.
  - All age compares use signed 6-bit differences.
- Full: when baseSqN+LENGTH-1 is allocated, OUT_maxSqN is reached; stalling is the front end's job.
- Empty: head invalid, no commit, baseSqN holds.
- Reset mid-operation discards all entries and clears in-flight outputs the next cycle.
- OUT_curSqN and OUT_maxSqN are registered copies of the updated baseSqN.

Test Plan:
- Reset, insert sqN 0,1 (nm 3,4; tags 40,41), wb sqN 0 and 1 in the same cycle -> two cycles later OUT_comValid=2'b11, RegNm 3/4, RegTag 40/41, ComSqN 0/1; OUT_curSqN=2, OUT_maxSqN=33 mod 64 = 33.
- Insert sqN 0,1,2; wb 1 and 2 only -> no commit; then wb 0 -> OUT_comValid=11 (sqN 0,1); next cycle OUT_comValid=01 (sqN 2).
- Insert sqN 0..5, IN_branchTaken with IN_branchSqN=2, then wb 0..5 -> only sqN 0,1,2 commit; OUT_curSqN=3 and stays there; wb 3..5 has no effect.
- Wrap: drive baseSqN to 62, insert 62,63,0,1 with wb -> commits in order 62,63,0,1; OUT_curSqN=2; OUT_maxSqN=33 mod 64.
- Fill LENGTH entries without wb -> OUT_maxSqN = baseSqN+31, no commits; wb head -> one commit, OUT_maxSqN advances by 1.
- Assert rst while entries are valid and executed -> next cycle OUT_comValid=0 and OUT_curSqN=0; a following wb sqN 0 causes no commit.
